ultrasonic_tx_burst: RTL and testbench
======================================

Name: ultrasonic_tx_burst

Overview:
- Transmit-side counterpart of the echo receive chain.
- On a start request, drives the transducer H-bridge with a complementary square-wave burst, with dead time between phases.
- Issues the one-cycle sys_start_pulse (T0) consumed by the echo correlator for ToF timing.
- Holds a receiver-blanking window through burst and ring-down, then times a listen window before reporting frame completion.

Parameters:
- HALF_PERIOD, 625, clk_50M cycles per half carrier period (625 gives 40 kHz at 50 MHz).
- DEAD_CYC, 10, cycles both drives are low at the end of each half period; must be < HALF_PERIOD.
- BLANK_CYC, 5000, ring-down blanking cycles after the burst (100 us).
- BRAKE_PERIODS, 2, inverted-phase damping periods; used only with TX_BRAKE_EN.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start_req  in  1  level; sampled only in IDLE.
- abort  in  1  synchronous abort; effective in any state.
- burst_cycles  in  8  carrier periods per burst; latched on acceptance.
- listen_len  in  20  listen-window length in cycles; latched on acceptance.
- tx_p  out  1  bridge drive, positive phase.
- tx_n  out  1  bridge drive, negative phase.
- sys_start_pulse  out  1  one-cycle T0 strobe.
- blank  out  1  receiver blanking, high during burst, brake and ring-down.
- busy  out  1  high from T0 through the last listen cycle.
- frame_done  out  1  one-cycle completion strobe.

Behaviour:
- Reset (asynchronous, immediate, any state): every output is 0, state is IDLE, all counters are 0.
- Clock and reset: single clock domain, clk_50M. Reset is asynchronous, active-low, on rst_n.
- States: IDLE -> BURST -> [BRAKE] -> RINGDOWN -> LISTEN -> IDLE. All outputs are registered.
- Acceptance:
  - Occurs on the clk_50M edge where state is IDLE, start_req=1 and abort=0.
  - burst_cycles is latched; a value of 0 is clamped to 1. listen_len is latched.
  - The first BURST cycle is T0 (cycle 0): sys_start_pulse=1, busy=1, blank=1, tx_p=1.
  - start_req outside IDLE is ignored. A start_req held high re-triggers on the first IDLE cycle after frame_done.
- BURST, per carrier period of 2*HALF_PERIOD cycles:
  - tx_p=1 for HALF_PERIOD-DEAD_CYC cycles, then both drives 0 for DEAD_CYC cycles.
  - tx_n=1 for HALF_PERIOD-DEAD_CYC cycles, then both drives 0 for DEAD_CYC cycles.
  - Burst occupies cycles 0 .. N*2*HALF_PERIOD-1, where N is the latched burst count.
  - tx_p and tx_n are never both 1, in any state.
- RINGDOWN:
  - Both drives 0, blank=1, for BLANK_CYC cycles.
  - blank falls on the first LISTEN cycle.
- LISTEN:
  - Drives 0, blank=0, busy=1, for the latched listen_len cycles.
  - listen_len=0 skips LISTEN entirely.
- Completion:
  - On the cycle after the last LISTEN cycle (or the last RINGDOWN cycle if listen_len=0), state returns to IDLE.
  - That same cycle: frame_done=1 for exactly one cycle, busy=0.
  - Without brake: frame_done lands at cycle N*2*HALF_PERIOD + BLANK_CYC + listen_len relative to T0.
- Abort:
  - Takes effect on the next edge: drives, blank, busy and all counters go to 0, state goes to IDLE.
  - No frame_done is issued.
  - Abort in IDLE has no effect. Abort on the same edge as a start_req blocks acceptance.
- Counters: a half-period counter and a period counter sized to parameters, and a 20-bit window counter. No wrap is possible: each counter is reloaded at every state entry.

Optional Feature:
- TX_BRAKE_EN defined:
  - After BURST, a BRAKE state runs for BRAKE_PERIODS carrier periods with inverted phase: tx_n leads, same dead-time rule.
  - blank stays 1 throughout BRAKE.
  - RINGDOWN and all later events shift by BRAKE_PERIODS*2*HALF_PERIOD cycles.
  - Abort applies in BRAKE exactly as in other states.
- TX_BRAKE_EN undefined:
  - No BRAKE state exists; BURST goes directly to RINGDOWN.
  - BRAKE_PERIODS is ignored.

Test Plan:
- Nominal frame: burst_cycles=8, listen_len=20000, start_req pulsed one cycle.
  - sys_start_pulse high for exactly 1 cycle at T0.
  - tx_p high at cycles 0-614, both drives low at 615-624, tx_n high at 625-1239.
  - Last drive edge falls by cycle 9999.
  - blank falls at cycle 15000.
  - frame_done at cycle 35000, with busy low the same cycle.
- Dead-time and exclusivity check over the whole frame: tx_p&tx_n never 1; every phase change passes through exactly 10 cycles of both-low.
- burst_cycles=0, listen_len=0:
  - Exactly 1 carrier period is emitted (cycles 0-1249).
  - frame_done at cycle 6250; no LISTEN cycle occurs.
- Abort during the cycle-3000 BURST: all outputs 0 on the next edge, no frame_done, and a new start_req is accepted 1 cycle later.
- rst_n asserted mid-RINGDOWN: outputs drop to 0 asynchronously, before the next edge. After release, an idle start_req=0 holds all outputs at 0.
- Brake with TX_BRAKE_EN, burst_cycles=8, listen_len=20000:
  - tx_n leads at cycle 10000.
  - blank falls at cycle 17500.
  - frame_done at cycle 37500.

Source files
------------

// File: rtl/ultrasonic_tx_burst.sv
// Ultrasonic transmit burst sequencer: complementary H-bridge drive with dead time, T0 strobe,
// receiver blanking and listen window. Define TX_BRAKE_EN to add an inverted-phase damping state.
module ultrasonic_tx_burst #(
  parameter int unsigned HALF_PERIOD   = 625,
  parameter int unsigned DEAD_CYC      = 10,
  parameter int unsigned BLANK_CYC     = 5000,
  parameter int unsigned BRAKE_PERIODS = 2
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        start_req,
  input  logic        abort,
  input  logic [7:0]  burst_cycles,
  input  logic [19:0] listen_len,
  output logic        tx_p,
  output logic        tx_n,
  output logic        sys_start_pulse,
  output logic        blank,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned PW = ($clog2(BRAKE_PERIODS + 1) > 8) ? $clog2(BRAKE_PERIODS + 1) : 8;
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [HW-1:0] DRIVE_LEN  = HW'(HALF_PERIOD - DEAD_CYC);
  localparam logic [19:0]   BLANK_LAST = 20'(BLANK_CYC - 1);
`ifdef TX_BRAKE_EN
  localparam logic [PW-1:0] BRAKE_LAST = PW'(BRAKE_PERIODS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
`ifdef TX_BRAKE_EN
    S_BRAKE,
`endif
    S_RINGDOWN,
    S_LISTEN
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic          sel_q, sel_d;
  logic [PW-1:0] period_q, period_d;
  logic [19:0]   win_q, win_d;
  logic [7:0]    burst_n_q, burst_n_d;
  logic [19:0]   listen_n_q, listen_n_d;
  logic          done_d;

  logic tx_p_q, tx_p_d, tx_n_q, tx_n_d, start_q, start_d;
  logic blank_q, blank_d, busy_q, busy_d, frame_done_q, frame_done_d;

  logic          carrier_active;
  logic [PW-1:0] period_last;
  state_e        after_carrier;
  logic          drive_on;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      half_q       <= '0;
      sel_q        <= 1'b0;
      period_q     <= '0;
      win_q        <= '0;
      burst_n_q    <= '0;
      listen_n_q   <= '0;
      tx_p_q       <= 1'b0;
      tx_n_q       <= 1'b0;
      start_q      <= 1'b0;
      blank_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      sel_q        <= sel_d;
      period_q     <= period_d;
      win_q        <= win_d;
      burst_n_q    <= burst_n_d;
      listen_n_q   <= listen_n_d;
      tx_p_q       <= tx_p_d;
      tx_n_q       <= tx_n_d;
      start_q      <= start_d;
      blank_q      <= blank_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    half_d         = half_q;
    sel_d          = sel_q;
    period_d       = period_q;
    win_d          = win_q;
    burst_n_d      = burst_n_q;
    listen_n_d     = listen_n_q;
    done_d         = 1'b0;
    carrier_active = 1'b0;
    period_last    = '0;
    after_carrier  = S_RINGDOWN;

    if (abort) begin
      // counters are already zero in IDLE, so abort there is a no-op
      state_d  = S_IDLE;
      half_d   = '0;
      sel_d    = 1'b0;
      period_d = '0;
      win_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_d    = S_BURST;
            burst_n_d  = (burst_cycles == 8'd0) ? 8'd1 : burst_cycles;
            listen_n_d = listen_len;
          end
        end
        S_BURST: begin
          carrier_active = 1'b1;
          period_last    = PW'(burst_n_q - 8'd1);
`ifdef TX_BRAKE_EN
          after_carrier  = S_BRAKE;
`endif
        end
`ifdef TX_BRAKE_EN
        S_BRAKE: begin
          carrier_active = 1'b1;
          period_last    = BRAKE_LAST;
        end
`endif
        S_RINGDOWN: begin
          if (win_q == BLANK_LAST) begin
            win_d = '0;
            if (listen_n_q == 20'd0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_LISTEN;
            end
          end else begin
            win_d = win_q + 20'd1;
          end
        end
        S_LISTEN: begin
          if (win_q == listen_n_q - 20'd1) begin
            win_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            win_d = win_q + 20'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Shared carrier stepping: half-period counter, phase select, period count.
      if (carrier_active) begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          sel_d  = ~sel_q;
          if (sel_q) begin
            if (period_q == period_last) begin
              period_d = '0;
              state_d  = after_carrier;
            end else begin
              period_d = period_q + PW'(1);
            end
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
    end
  end

  // Outputs are decoded from the next-cycle state so every port comes straight from a flop.
  always_comb begin
    tx_p_d       = 1'b0;
    tx_n_d       = 1'b0;
    drive_on     = (half_d < DRIVE_LEN);
    case (state_d)
      S_BURST: begin
        tx_p_d = ~sel_d & drive_on;
        tx_n_d =  sel_d & drive_on;
      end
`ifdef TX_BRAKE_EN
      S_BRAKE: begin
        tx_n_d = ~sel_d & drive_on;
        tx_p_d =  sel_d & drive_on;
      end
`endif
      default: ;
    endcase
    start_d      = (state_q == S_IDLE) && (state_d == S_BURST);
    blank_d      = (state_d == S_BURST) || (state_d == S_RINGDOWN)
`ifdef TX_BRAKE_EN
                   || (state_d == S_BRAKE)
`endif
                   ;
    busy_d       = (state_d != S_IDLE);
    frame_done_d = done_d;
  end

  assign tx_p            = tx_p_q;
  assign tx_n            = tx_n_q;
  assign sys_start_pulse = start_q;
  assign blank           = blank_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_ultrasonic_tx_burst.sv
// Self-checking bench for ultrasonic_tx_burst: each frame is compared cycle by cycle against a
// timeline computed arithmetically from T0. Honours TX_BRAKE_EN when defined.
module tb_ultrasonic_tx_burst;

  localparam int HP    = 625;
  localparam int DEAD  = 10;
  localparam int BLANK = 5000;
  localparam int P     = 2 * HP;
`ifdef TX_BRAKE_EN
  localparam int BRAKE_LEN = 2 * P;
`else
  localparam int BRAKE_LEN = 0;
`endif

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_req = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  burst_cycles = '0;
  logic [19:0] listen_len = '0;
  logic        tx_p, tx_n, sys_start_pulse, blank, busy, frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int shown    = 0;

  ultrasonic_tx_burst dut (
    .clk_50M        (clk_50M),
    .rst_n          (rst_n),
    .start_req      (start_req),
    .abort          (abort),
    .burst_cycles   (burst_cycles),
    .listen_len     (listen_len),
    .tx_p           (tx_p),
    .tx_n           (tx_n),
    .sys_start_pulse(sys_start_pulse),
    .blank          (blank),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #10 clk_50M = ~clk_50M;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Cycle at which frame_done is expected, relative to T0.
  function automatic int frame_end(input int n, input int l);
    int nb;
    nb = (n == 0) ? 1 : n;
    return nb * P + BRAKE_LEN + BLANK + l;
  endfunction

  // Expected {tx_p, tx_n, sys_start_pulse, blank, busy, frame_done} at cycle t after T0.
  function automatic logic [5:0] model(input int t, input int n, input int l);
    int nb, tbe, tre, tle, tde, ph;
    logic [5:0] r;
    nb  = (n == 0) ? 1 : n;
    tbe = nb * P;
    tre = tbe + BRAKE_LEN;
    tle = tre + BLANK;
    tde = tle + l;
    r   = '0;
    if (t < tbe) begin
      ph   = t % P;
      r[5] = (ph < HP - DEAD);
      r[4] = (ph >= HP) && (ph < P - DEAD);
    end else if (t < tre) begin
      ph   = (t - tbe) % P;
      r[4] = (ph < HP - DEAD);
      r[5] = (ph >= HP) && (ph < P - DEAD);
    end
    r[3] = (t == 0);
    r[2] = (t < tle);
    r[1] = (t < tde);
    r[0] = (t == tde);
    return r;
  endfunction

  function automatic logic [5:0] observed();
    return {tx_p, tx_n, sys_start_pulse, blank, busy, frame_done};
  endfunction

  // Frame whose T0 is the next negedge sample; ends at its frame_done cycle.
  task automatic run_frame(input string name, input int n, input int l, input bit keep_req,
                           input int next_n, input int next_l);
    int te;
    logic [5:0] exp_v, obs;
    te = frame_end(n, l);
    for (int t = 0; t <= te; t++) begin
      @(negedge clk_50M);
      exp_v = model(t, n, l);
      obs   = observed();
      n_checks++;
      if (obs !== exp_v) begin
        if (shown < 20) $display("FAIL %s t=%0d got=%b exp=%b (tx_p,tx_n,t0,blank,busy,done)", name, t, obs, exp_v);
        shown++;
      end else n_pass++;
      n_checks++;
      if ((tx_p & tx_n) !== 1'b0) begin
        if (shown < 20) $display("FAIL %s_overlap t=%0d got tx_p&tx_n=%b exp=0", name, t, tx_p & tx_n);
        shown++;
      end else n_pass++;
      if (t == 0) begin
        if (!keep_req) start_req = 1'b0;
        burst_cycles = next_n[7:0];
        listen_len   = next_l[19:0];
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_50M);
      n_checks++;
      if (observed() !== 6'b0) begin
        if (shown < 20) $display("FAIL %s cyc=%0d got=%b exp=000000", name, i, observed());
        shown++;
      end else n_pass++;
    end
  endtask

  task automatic launch(input int n, input int l);
    @(negedge clk_50M);
    burst_cycles = n[7:0];
    listen_len   = l[19:0];
    start_req    = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (observed() !== 6'b0) begin
      $display("FAIL reset_state got=%b exp=000000", observed());
      shown++;
    end else n_pass++;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    check_idle("reset_idle", 4);
  endtask

  task automatic test_nominal();
    launch(8, 20000);
    run_frame("nominal", 8, 20000, 1'b0, 8, 20000);
    check_idle("nominal_after", 4);
  endtask

  task automatic test_zero_counts();
    launch(0, 0);
    run_frame("zero_counts", 0, 0, 1'b0, 0, 0);
    check_idle("zero_after", 4);
  endtask

  task automatic test_abort();
    logic [5:0] exp_v;
    launch(8, 100);
    for (int t = 0; t <= 3000; t++) begin
      @(negedge clk_50M);
      exp_v = model(t, 8, 100);
      n_checks++;
      if (observed() !== exp_v) begin
        if (shown < 20) $display("FAIL abort_pre t=%0d got=%b exp=%b", t, observed(), exp_v);
        shown++;
      end else n_pass++;
      if (t == 0) start_req = 1'b0;
    end
    abort = 1'b1;
    check_idle("abort_drop", 1);
    abort        = 1'b0;
    start_req    = 1'b1;
    burst_cycles = 8'd1;
    listen_len   = 20'd0;
    @(negedge clk_50M);
    n_checks++;
    if (observed() !== model(0, 1, 0)) begin
      $display("FAIL abort_restart got=%b exp=%b", observed(), model(0, 1, 0));
      shown++;
    end else n_pass++;
    // abort with start_req both high: drop to IDLE, then acceptance stays blocked
    abort = 1'b1;
    check_idle("abort_blocks_start", 5);
    abort     = 1'b0;
    start_req = 1'b0;
    check_idle("abort_after", 3);
  endtask

  task automatic test_reset_mid_ringdown();
    logic [5:0] exp_v;
    launch(0, 50);
    for (int t = 0; t <= 3000; t++) begin
      @(negedge clk_50M);
      exp_v = model(t, 0, 50);
      n_checks++;
      if (observed() !== exp_v) begin
        if (shown < 20) $display("FAIL rst_pre t=%0d got=%b exp=%b", t, observed(), exp_v);
        shown++;
      end else n_pass++;
      if (t == 0) start_req = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== 6'b0) begin
      $display("FAIL rst_async got=%b exp=000000", observed());
      shown++;
    end else n_pass++;
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    check_idle("rst_release_idle", 6);
  endtask

  task automatic test_random_frame();
    int n, l;
    n = int'($urandom_range(1, 3));
    l = int'($urandom_range(1, 500));
    launch(n, l);
    run_frame("random_frame", n, l, 1'b0, n, l);
    check_idle("random_after", 3);
  endtask

  task automatic test_back_to_back();
    int n1, l1, n2, l2;
    n1 = int'($urandom_range(0, 2));
    l1 = int'($urandom_range(0, 300));
    n2 = int'($urandom_range(0, 2));
    l2 = int'($urandom_range(0, 300));
    launch(n1, l1);
    run_frame("b2b_first", n1, l1, 1'b1, n2, l2);
    run_frame("b2b_second", n2, l2, 1'b0, n2, l2);
    check_idle("b2b_after", 3);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_counts();
    test_abort();
    test_reset_mid_ringdown();
    test_random_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
